// File: rtl/tlb.sv
// Fully associative TLB: hits answered locally, misses forwarded to the page-table walker.
// Ports: clk_i/rst_i (sync, active-high); core side req_i, vaddr_i, flush_i, busy_o,
//   valid_o, error_o, paddr_o; walker side ptw_req_o, ptw_vaddr_o, ptw_valid_i,
//   ptw_error_i, ptw_paddr_i. Define TLB_STATS_EN to add hit_count_o/miss_count_o.

package params_pkg;
    localparam int VADDR_WIDTH = 32;
    localparam int PADDR_WIDTH = 20;
endpackage

module tlb #(
    parameter int VADDR_WIDTH  = params_pkg::VADDR_WIDTH,
    parameter int PADDR_WIDTH  = params_pkg::PADDR_WIDTH,
    parameter int OFFSET_WIDTH = 12,
    parameter int NUM_ENTRIES  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic [VADDR_WIDTH-1:0] vaddr_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic                   error_o,
    output logic [PADDR_WIDTH-1:0] paddr_o,
    output logic                   ptw_req_o,
    output logic [VADDR_WIDTH-1:0] ptw_vaddr_o,
    input  logic                   ptw_valid_i,
    input  logic                   ptw_error_i,
    input  logic [PADDR_WIDTH-1:0] ptw_paddr_i
`ifdef TLB_STATS_EN
    ,
    output logic [31:0]            hit_count_o,
    output logic [31:0]            miss_count_o
`endif
);

    localparam int VPN_W = VADDR_WIDTH - OFFSET_WIDTH;
    localparam int PPN_W = PADDR_WIDTH - OFFSET_WIDTH;
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

    state_t state_q, state_d;

    logic [NUM_ENTRIES-1:0] vld_q;
    logic [VPN_W-1:0]       vpn_q [NUM_ENTRIES];
    logic [PPN_W-1:0]       ppn_q [NUM_ENTRIES];
    logic [IDX_W-1:0]       ptr_q;
    logic [VADDR_WIDTH-1:0] vaddr_q;
    logic                   err_q;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             has_free;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim;
    logic [VPN_W-1:0] req_vpn;

    // Walker offset bits are not used: the offset always comes from the vaddr.
    logic unused_ok;
    assign unused_ok = ^ptw_paddr_i[OFFSET_WIDTH-1:0];

    assign req_vpn = vaddr_i[VADDR_WIDTH-1:OFFSET_WIDTH];

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (vld_q[i] && vpn_q[i] == req_vpn) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Descending scan leaves the lowest-index free slot selected.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign victim = has_free ? free_idx : ptr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_i) state_d = hit ? RESP : WALK;
            WALK: if (ptw_error_i || ptw_valid_i) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vld_q   <= '0;
            ptr_q   <= '0;
            vaddr_q <= '0;
            err_q   <= 1'b0;
            paddr_o <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        vaddr_q <= vaddr_i;
                        err_q   <= 1'b0;
                        if (hit) begin
                            paddr_o <= {ppn_q[hit_idx],
                                        vaddr_i[OFFSET_WIDTH-1:0]};
                        end
                    end
                end
                WALK: begin
                    if (ptw_error_i) begin
                        err_q <= 1'b1;
                    end else if (ptw_valid_i) begin
                        paddr_o <= {ptw_paddr_i[PADDR_WIDTH-1:OFFSET_WIDTH],
                                    vaddr_q[OFFSET_WIDTH-1:0]};
                        // A concurrent flush suppresses the fill entirely,
                        // including the pointer advance.
                        if (!flush_i) begin
                            vld_q[victim] <= 1'b1;
                            vpn_q[victim] <= vaddr_q[VADDR_WIDTH-1:OFFSET_WIDTH];
                            ppn_q[victim] <= ptw_paddr_i[PADDR_WIDTH-1:OFFSET_WIDTH];
                            if (!has_free) ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (flush_i) vld_q <= '0;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign ptw_req_o   = (state_q == WALK);
    assign ptw_vaddr_o = vaddr_q;
    assign valid_o     = (state_q == RESP) && !err_q;
    assign error_o     = (state_q == RESP) && err_q;

`ifdef TLB_STATS_EN
    logic accept;
    assign accept = (state_q == IDLE) && req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count_o != '1) hit_count_o <= hit_count_o + 1'b1;
            end else begin
                if (miss_count_o != '1) miss_count_o <= miss_count_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tlb.sv
// Randomized scoreboard bench for tlb with a table-level reference model.
// Directed cases cover fill, hit, walk fault, eviction, flush-at-fill and reset mid-walk.

module tb_tlb;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] vaddr_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, valid_o, error_o, ptw_req_o;
    logic [19:0] paddr_o;
    logic [31:0] ptw_vaddr_o;
    logic        ptw_valid_i = 1'b0;
    logic        ptw_error_i = 1'b0;
    logic [19:0] ptw_paddr_i = '0;

    always #5 clk = ~clk;

    tlb dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .vaddr_i     (vaddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .error_o     (error_o),
        .paddr_o     (paddr_o),
        .ptw_req_o   (ptw_req_o),
        .ptw_vaddr_o (ptw_vaddr_o),
        .ptw_valid_i (ptw_valid_i),
        .ptw_error_i (ptw_error_i),
        .ptw_paddr_i (ptw_paddr_i)
    );

    int vec  = 0;
    int errs = 0;

    typedef struct {
        bit          err;
        logic [19:0] pa;
    } exp_t;

    exp_t sq[$];

    // Reference: a 4-slot table of (vpn, ppn) pages plus a round-robin pointer.
    bit          m_vld [4];
    logic [19:0] m_vpn [4];
    logic [7:0]  m_ppn [4];
    int          m_ptr;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) m_vld[i] = 0;
    endfunction

    function automatic int m_find(input logic [19:0] v);
        for (int i = 0; i < 4; i++)
            if (m_vld[i] && m_vpn[i] == v) return i;
        return -1;
    endfunction

    function automatic void m_fill(input logic [19:0] v, input logic [7:0] p);
        int slot = -1;
        for (int i = 0; i < 4; i++) begin
            if (!m_vld[i]) begin
                slot = i;
                break;
            end
        end
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % 4;
        end
        m_vld[slot] = 1;
        m_vpn[slot] = v;
        m_ppn[slot] = p;
    endfunction

    always @(negedge clk) begin
        if (!rst_i && (valid_o || error_o)) begin
            if (sq.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL unexpected_resp: got valid=%0b error=%0b expected none",
                         valid_o, error_o);
            end else begin
                exp_t e;
                e = sq.pop_front();
                chk("resp_valid", 64'(valid_o), 64'(!e.err));
                chk("resp_error", 64'(error_o), 64'(e.err));
                if (!e.err) chk("resp_paddr", 64'(paddr_o), 64'(e.pa));
            end
        end
    end

    // kind: 0 walker ok, 1 fault, 2 fault and valid together.
    task automatic xact(input logic [31:0] va, input int kind,
                        input logic [7:0] ppn, input bit fl, input int dly);
        int   hi;
        exp_t e;
        hi = m_find(va[31:12]);
        @(posedge clk); #1;
        req_i   = 1'b1;
        vaddr_i = va;
        if (hi >= 0) begin
            e.err = 0;
            e.pa  = {m_ppn[hi], va[11:0]};
            sq.push_back(e);
        end
        @(posedge clk); #1;
        if (hi >= 0) begin
            req_i = 1'b0;
            chk("hit_no_walk", 64'(ptw_req_o), 64'(0));
        end else begin
            chk("walk_req", 64'(ptw_req_o), 64'(1));
            chk("walk_vaddr", 64'(ptw_vaddr_o), 64'(va));
            vaddr_i = $urandom;
            for (int d = 0; d < dly; d++) begin
                @(posedge clk); #1;
                chk("walk_hold", 64'(ptw_req_o), 64'(1));
                chk("walk_vaddr_stable", 64'(ptw_vaddr_o), 64'(va));
            end
            ptw_valid_i = (kind != 1);
            ptw_error_i = (kind != 0);
            ptw_paddr_i = {ppn, 12'($urandom)};
            flush_i     = fl;
            e.err = (kind != 0);
            e.pa  = {ppn, va[11:0]};
            sq.push_back(e);
            if (fl) m_clear();
            else if (kind == 0) m_fill(va[31:12], ppn);
            @(posedge clk); #1;
            ptw_valid_i = 1'b0;
            ptw_error_i = 1'b0;
            flush_i     = 1'b0;
            req_i       = 1'b0;
        end
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy_o), 64'(0));
        chk("idle_ptw_req", 64'(ptw_req_o), 64'(0));
    endtask

    initial begin
        m_clear();
        m_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_error", 64'(error_o), 64'(0));
        chk("rst_paddr", 64'(paddr_o), 64'(0));
        chk("rst_ptw_req", 64'(ptw_req_o), 64'(0));
        chk("rst_ptw_vaddr", 64'(ptw_vaddr_o), 64'(0));
        rst_i = 1'b0;

        xact(32'h0000_1234, 0, 8'h05, 0, 0);
        xact(32'h0000_1ABC, 0, 8'h00, 0, 0);
        xact(32'h0000_7000, 2, 8'h33, 0, 1);
        xact(32'h0000_7000, 0, 8'h77, 0, 2);

        xact(32'h0000_2010, 0, 8'h12, 0, 0);
        xact(32'h0000_3020, 0, 8'h13, 0, 0);
        xact(32'h0000_4030, 0, 8'h14, 0, 0);
        xact(32'h0000_5040, 0, 8'h15, 0, 0);
        xact(32'h0000_1FFF, 0, 8'h21, 0, 0);
        xact(32'h0000_2123, 0, 8'h00, 0, 0);

        xact(32'h0000_9ABC, 0, 8'h99, 1, 0);
        xact(32'h0000_9ABC, 0, 8'h9A, 0, 0);

        @(posedge clk); #1;
        req_i   = 1'b1;
        vaddr_i = 32'h0000_C000;
        @(posedge clk); #1;
        chk("rstwalk_req", 64'(ptw_req_o), 64'(1));
        rst_i = 1'b1;
        req_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_clear();
        m_ptr = 0;
        chk("rstwalk_ptw_req", 64'(ptw_req_o), 64'(0));
        chk("rstwalk_busy", 64'(busy_o), 64'(0));
        ptw_valid_i = 1'b1;
        ptw_paddr_i = 20'hCC000;
        @(posedge clk); #1;
        ptw_valid_i = 1'b0;
        chk("late_no_valid", 64'(valid_o), 64'(0));
        chk("late_no_busy", 64'(busy_o), 64'(0));
        xact(32'h0000_C000, 0, 8'hC1, 0, 0);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] va;
            int r, kind;
            va = {17'h0, 3'($urandom_range(0, 7)), 12'($urandom)};
            r = $urandom_range(0, 9);
            kind = (r < 8) ? 0 : (r == 8 ? 1 : 2);
            xact(va, kind, 8'($urandom), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                flush_i = 1'b1;
                m_clear();
                @(posedge clk); #1;
                flush_i = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
